// File: rtl/ssd1306_i2c_tx_if.sv
// Request/response and I2C pin bundle between a host and the SSD1306 I2C write transmitter.
// The master side is the host plus the bus environment; it also supplies the sampled SDA level.
interface ssd1306_i2c_tx_if;
  logic [7:0] tx_ctrl;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic       ack_err;
  logic       scl;
  logic       sda_low;
  logic       sda_in;

  modport master (
    output tx_ctrl, tx_data, tx_start, sda_in,
    input  tx_done, ack_err, scl, sda_low
  );

  modport slave (
    input  tx_ctrl, tx_data, tx_start, sda_in,
    output tx_done, ack_err, scl, sda_low
  );
endinterface

// File: rtl/ssd1306_i2c_tx.sv
// Single-transaction I2C writer for an SSD1306: START, address+W, control byte, data byte, STOP.
// Every pin level is registered and changes only on quarter-SCL ticks.
module ssd1306_i2c_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h3C,
  parameter int         QUARTER    = 125
) (
  input logic             clk,
  input logic             rst,
  ssd1306_i2c_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_CTRL  = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam logic [11:0] Q_LAST    = 12'(QUARTER - 1);
  localparam logic [7:0]  ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  state_t      state_r;
  logic [11:0] qcnt_r;
  logic [1:0]  qtr_r;
  logic [3:0]  bit_r;
  logic [7:0]  ctrl_r;
  logic [7:0]  data_r;
  logic        nack_r;
  logic        tx_done_r;
  logic        ack_err_r;
  logic        scl_r;
  logic        sda_low_r;

  logic        tick_s;
  state_t      nxt_state_s;
  logic [1:0]  nxt_qtr_s;
  logic [3:0]  nxt_bit_s;
  logic        nack_s;
  logic [7:0]  nxt_byte_s;

  // Pin levels {scl, sda_low} for a given position inside the transaction.
  function automatic logic [1:0] pins(input state_t st, input logic [1:0] q,
                                      input logic [3:0] b, input logic [7:0] byte_v);
    logic [1:0] r;
    logic [2:0] idx;
    r   = 2'b10;
    idx = 3'd7 - b[2:0];
    case (st)
      S_START: begin
        case (q)
          2'd0:    r = 2'b10;
          2'd1:    r = 2'b11;
          2'd2:    r = 2'b11;
          default: r = 2'b01;
        endcase
      end
      S_ADDR, S_CTRL, S_DATA: begin
        r[1] = (q == 2'd1) || (q == 2'd2);
        r[0] = (b == 4'd8) ? 1'b0 : ~byte_v[idx];
      end
      S_STOP: begin
        case (q)
          2'd0:    r = 2'b01;
          2'd1:    r = 2'b11;
          default: r = 2'b10;
        endcase
      end
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  assign tick_s = (qcnt_r == Q_LAST);

  // Position the FSM moves to on the next quarter tick, plus the ACK-slot NACK capture.
  always_comb begin
    nxt_state_s = state_r;
    nxt_qtr_s   = qtr_r + 2'd1;
    nxt_bit_s   = bit_r;
    if (((state_r == S_ADDR) || (state_r == S_CTRL) || (state_r == S_DATA)) &&
        (bit_r == 4'd8) && (qtr_r == 2'd1)) begin
      nack_s = nack_r | bus.sda_in;
    end else begin
      nack_s = nack_r;
    end
    if (qtr_r == 2'd3) begin
      case (state_r)
        S_START: begin
          nxt_state_s = S_ADDR;
          nxt_bit_s   = 4'd0;
        end
        S_ADDR, S_CTRL, S_DATA: begin
          if (bit_r == 4'd8) begin
            nxt_bit_s = 4'd0;
            // A NACK on any byte abandons the rest and closes the bus.
            if (nack_r || (state_r == S_DATA)) begin
              nxt_state_s = S_STOP;
            end else if (state_r == S_ADDR) begin
              nxt_state_s = S_CTRL;
            end else begin
              nxt_state_s = S_DATA;
            end
          end else begin
            nxt_bit_s = bit_r + 4'd1;
          end
        end
        S_STOP:  nxt_state_s = S_IDLE;
        default: nxt_state_s = S_IDLE;
      endcase
    end else begin
      nxt_state_s = state_r;
    end
  end

  // Byte shifted out in the state the FSM is about to enter.
  always_comb begin
    case (nxt_state_s)
      S_ADDR:  nxt_byte_s = ADDR_BYTE;
      S_CTRL:  nxt_byte_s = ctrl_r;
      S_DATA:  nxt_byte_s = data_r;
      default: nxt_byte_s = 8'h00;
    endcase
  end

  // Transaction FSM with registered pin, status and latch outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      qcnt_r    <= 12'd0;
      qtr_r     <= 2'd0;
      bit_r     <= 4'd0;
      ctrl_r    <= 8'h00;
      data_r    <= 8'h00;
      nack_r    <= 1'b0;
      tx_done_r <= 1'b1;
      ack_err_r <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          qcnt_r    <= 12'd0;
          ack_err_r <= 1'b0;
          if (bus.tx_start) begin
            state_r   <= S_START;
            qtr_r     <= 2'd0;
            bit_r     <= 4'd0;
            nack_r    <= 1'b0;
            ctrl_r    <= bus.tx_ctrl;
            data_r    <= bus.tx_data;
            tx_done_r <= 1'b0;
            {scl_r, sda_low_r} <= pins(S_START, 2'd0, 4'd0, 8'h00);
          end else begin
            tx_done_r <= 1'b1;
            {scl_r, sda_low_r} <= 2'b10;
          end
        end
        default: begin
          ack_err_r <= 1'b0;
          if (tick_s) begin
            qcnt_r  <= 12'd0;
            state_r <= nxt_state_s;
            qtr_r   <= nxt_qtr_s;
            bit_r   <= nxt_bit_s;
            {scl_r, sda_low_r} <= pins(nxt_state_s, nxt_qtr_s, nxt_bit_s, nxt_byte_s);
            if (nxt_state_s == S_IDLE) begin
              tx_done_r <= 1'b1;
              ack_err_r <= nack_s;
              nack_r    <= 1'b0;
            end else begin
              nack_r    <= nack_s;
            end
          end else begin
            qcnt_r <= qcnt_r + 12'd1;
          end
        end
      endcase
    end
  end

  assign bus.tx_done = tx_done_r;
  assign bus.ack_err = ack_err_r;
  assign bus.scl     = scl_r;
  assign bus.sda_low = sda_low_r;

endmodule

// File: tb/tb_ssd1306_i2c_tx.sv
// Directed bench for ssd1306_i2c_tx (QUARTER=4): a bus monitor decodes SDA bytes and START/STOP,
// an ACK responder drives sda_in, and a vector table plus hand sequences check timing and status.
module tb_ssd1306_i2c_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssd1306_i2c_tx_if bus ();

  ssd1306_i2c_tx #(.SLAVE_ADDR(7'h3C), .QUARTER(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       resp_pull = 1'b0;
  logic [3:0] ack_mask  = 4'b1111;
  assign bus.sda_in = ~(bus.sda_low | resp_pull);

  int n_tot = 0;
  int n_bad = 0;

  int         n_start, n_stop, n_viol, n_low, n_ack, n_bytes, bitpos, byte_idx;
  logic [7:0] got [0:7];
  logic [7:0] shreg;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       mon_clr  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor and ACK responder, sampled on the falling clk edge.
  initial begin
    logic cs, cd;
    n_start = 0; n_stop = 0; n_viol = 0; n_low = 0; n_ack = 0; n_bytes = 0;
    bitpos = 0; byte_idx = 0; shreg = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        n_start = 0; n_stop = 0; n_viol = 0; n_low = 0; n_ack = 0; n_bytes = 0;
        bitpos = 0; byte_idx = 0; resp_pull = 1'b0;
      end
      cs = bus.scl;
      cd = bus.sda_in;
      if (prev_scl && cs && (prev_sda != cd)) begin
        if (!cd) begin
          n_start++;
          bitpos = 0;
          byte_idx = 0;
        end else begin
          n_stop++;
        end
      end else if ((prev_scl != cs) && (prev_sda != cd)) begin
        n_viol++;
      end
      if (!prev_scl && cs) begin
        if (bitpos < 8) begin
          shreg = {shreg[6:0], cd};
          bitpos++;
          if (bitpos == 8 && n_bytes < 8) begin
            got[n_bytes] = shreg;
            n_bytes++;
          end
        end else begin
          bitpos = 0;
          if (byte_idx < 3) byte_idx++;
        end
      end
      if (prev_scl && !cs) resp_pull = (bitpos == 8) && ack_mask[byte_idx];
      if (!bus.tx_done) n_low++;
      if (bus.ack_err) n_ack++;
      prev_scl = cs;
      prev_sda = cd;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.tx_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_done) chk({name, "_timeout"}, 0, 1);
  endtask

  // One transaction: start at a falling edge, wait for tx_done, then let ack_err settle.
  task automatic run_txn(input logic [7:0] c, input logic [7:0] d, input logic [3:0] m,
                         input string name);
    ack_mask     = m;
    bus.tx_ctrl  = c;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    mon_clr      = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    #1 mon_clr   = 1'b0;
    wait_idle(name);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] data;
    logic [3:0] mask;
    int         len;
    int         nbytes;
    int         ack;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    logic [7:0] exp_b [0:2];
    vecs[0] = '{8'h40, 8'hA5, 4'b1111, 464, 3, 0};
    vecs[1] = '{8'h00, 8'hAE, 4'b1111, 464, 3, 0};
    vecs[2] = '{8'h40, 8'h5A, 4'b0000, 176, 1, 1};
    vecs[3] = '{8'h40, 8'h3C, 4'b0011, 464, 3, 1};
    vecs[4] = '{8'h00, 8'h81, 4'b0001, 320, 2, 1};
    vecs[5] = '{8'h40, 8'hFF, 4'b1111, 464, 3, 0};
    vecs[6] = '{8'h00, 8'h00, 4'b1111, 464, 3, 0};

    bus.tx_ctrl  = 8'h00;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx_done", int'(bus.tx_done), 1);
    chk("rst_ack_err", int'(bus.ack_err), 0);
    chk("rst_scl",     int'(bus.scl),     1);
    chk("rst_sda_low", int'(bus.sda_low), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].ctrl, vecs[i].data, vecs[i].mask, $sformatf("v%0d", i));
      exp_b[0] = 8'h78;
      exp_b[1] = vecs[i].ctrl;
      exp_b[2] = vecs[i].data;
      chk($sformatf("v%0d_len", i),    n_low,   vecs[i].len);
      chk($sformatf("v%0d_nbytes", i), n_bytes, vecs[i].nbytes);
      for (int k = 0; k < vecs[i].nbytes && k < n_bytes; k++)
        chk($sformatf("v%0d_byte%0d", i, k), int'(got[k]), int'(exp_b[k]));
      chk($sformatf("v%0d_ack_err", i), n_ack,   vecs[i].ack);
      chk($sformatf("v%0d_start", i),   n_start, 1);
      chk($sformatf("v%0d_stop", i),    n_stop,  1);
      chk($sformatf("v%0d_proto", i),   n_viol,  0);
    end

    // Back-to-back with tx_start held; mid-transaction tx_data changes must not reach SDA.
    ack_mask     = 4'b1111;
    bus.tx_ctrl  = 8'h40;
    bus.tx_data  = 8'h11;
    bus.tx_start = 1'b1;
    mon_clr      = 1'b1;
    @(negedge clk);
    #1 mon_clr   = 1'b0;
    repeat (200) @(negedge clk);
    bus.tx_data  = 8'hEE;
    wait_idle("b2b_first");
    bus.tx_data  = 8'h22;
    @(negedge clk);
    chk("b2b_reaccept", int'(bus.tx_done), 0);
    repeat (200) @(negedge clk);
    bus.tx_data  = 8'h55;
    wait_idle("b2b_second");
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_nbytes", n_bytes, 6);
    chk("b2b_byte2",  int'(got[2]), 8'h11);
    chk("b2b_byte3",  int'(got[3]), 8'h78);
    chk("b2b_byte5",  int'(got[5]), 8'h22);
    chk("b2b_len",    n_low,   928);
    chk("b2b_start",  n_start, 2);
    chk("b2b_stop",   n_stop,  2);
    chk("b2b_proto",  n_viol,  0);
    chk("b2b_ack",    n_ack,   0);

    // Asynchronous reset inside the DATA byte, bit index 3, second quarter (SCL high).
    bus.tx_ctrl  = 8'h40;
    bus.tx_data  = 8'hA5;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    repeat (357) @(negedge clk);
    chk("pre_rst_scl",     int'(bus.scl),     1);
    chk("pre_rst_sda_low", int'(bus.sda_low), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_scl",     int'(bus.scl),     1);
    chk("mid_rst_sda_low", int'(bus.sda_low), 0);
    chk("mid_rst_tx_done", int'(bus.tx_done), 1);
    chk("mid_rst_ack_err", int'(bus.ack_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(8'h00, 8'hC3, 4'b1111, "after_rst");
    chk("after_rst_len",   n_low,   464);
    chk("after_rst_nbyte", n_bytes, 3);
    chk("after_rst_byte1", int'(got[1]), 8'h00);
    chk("after_rst_byte2", int'(got[2]), 8'hC3);
    chk("after_rst_ack",   n_ack,   0);
    chk("after_rst_proto", n_viol,  0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd1306_i2c_tx.md
SSD1306_I2C_TX -- requirements
Module: ssd1306_i2c_tx

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h3C, 7-bit I2C address of the display; R/W bit is always 0 (write).
REQ-002 Parameter QUARTER, default 125, clk cycles per quarter SCL period; legal range 2..4095.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx_ctrl  input  8  SSD1306 control byte (8'h00 command, 8'h40 display data).
REQ-006 tx_data  input  8  payload byte.
REQ-007 tx_start  input  1  request to send one transaction.
REQ-008 tx_done  output  1  high = idle and ready to accept a request; low = busy.
REQ-009 ack_err  output  1  one-cycle pulse reporting a NACK on the transaction just ended.
REQ-010 scl  output  1  I2C clock, push-pull.
REQ-011 sda_low  output  1  1 = pull SDA low, 0 = release SDA (external pull-up).
REQ-012 sda_in  input  1  sampled SDA line level, synchronous to clk.

Function
REQ-013 A request is accepted on a rising clk edge where tx_start=1 and tx_done=1; tx_ctrl and tx_data are latched on that edge; tx_done goes low on the same edge.
REQ-014 tx_start while tx_done=0 is ignored; the latched bytes do not change during a transaction.
REQ-015 A quarter tick occurs every QUARTER clk cycles, measured from the accept edge; the counter is held at 0 in IDLE.
REQ-016 State sequence: IDLE -> START -> ADDR -> CTRL -> DATA -> STOP -> IDLE; each state advances only on a quarter tick.
REQ-017 START spans 4 quarters: Q0 scl=1, sda_low=0; Q1 scl=1, sda_low=1; Q2 scl=1, sda_low=1; Q3 scl=0, sda_low=1.
REQ-018 ADDR sends {SLAVE_ADDR,1'b0}; CTRL sends latched tx_ctrl; DATA sends latched tx_data; each byte is MSB first.
REQ-019 Each byte spans 9 bits of 4 quarters; per bit: Q0 scl=0 and SDA set to the bit (sda_low = ~bit); Q1 scl=1; Q2 scl=1; Q3 scl=0.
REQ-020 The 9th bit is the ACK slot: sda_low=0 for all 4 quarters; sda_in is sampled on the tick ending Q1; sample 1 = NACK.
REQ-021 On NACK, no further bytes are sent; the FSM goes directly to STOP.
REQ-022 STOP spans 4 quarters: Q0 scl=0, sda_low=1; Q1 scl=1, sda_low=1; Q2 scl=1, sda_low=0; Q3 scl=1, sda_low=0.
REQ-023 Error-free transaction length is exactly 116*QUARTER clk cycles from the accept edge to tx_done returning to 1.
REQ-024 The cycle tx_done returns to 1, ack_err pulses for one cycle if any NACK occurred in that transaction; otherwise it stays 0.
REQ-025 In IDLE, scl=1 and sda_low=0.
REQ-026 A new request may be accepted on the first edge at which tx_done=1 again; back-to-back transactions leave no extra idle quarters.
REQ-027 Bit and byte counters are sized so that the counts 0..8 and 0..3 do not wrap; the quarter counter wraps from QUARTER-1 to 0.

Reset
REQ-028 While rst=1, all of the following hold immediately, including when rst is asserted mid-transaction: state=IDLE, tx_done=1, ack_err=0, scl=1, sda_low=0, all counters and latches 0.
REQ-029 The first accept after reset release follows REQ-013 with no extra delay.

Verification (QUARTER=4)
REQ-030 tx_ctrl=8'h40, tx_data=8'hA5, responder ACKs all bytes -> SDA bytes 0x78, 0x40, 0xA5 with correct START and STOP; tx_done low for exactly 464 cycles; ack_err=0.
REQ-031 sda_in held at 1 (no device present) -> NACK at address; STOP follows immediately; tx_done returns after 4*(4+36+4)=176 cycles; ack_err pulses once.
REQ-032 tx_start held high continuously with a new byte each transaction -> consecutive transactions; the inputs are latched only at accept; changing tx_data mid-transaction has no effect on SDA.
REQ-033 rst asserted during the DATA bit 3 quarter -> same-cycle scl=1, sda_low=0, tx_done=1; the next request completes normally.
REQ-034 NACK on the DATA byte only -> all 3 bytes are sent; STOP follows; total length is 464 cycles; ack_err pulses once.
REQ-035 Protocol checker: SDA changes only while scl=0, except at the START and STOP edges, in every scenario above.
